fifo_bit_reader_ctrl: RTL and testbench
=======================================

Name: fifo_bit_reader_ctrl

Overview:
Sequences single-bit reads from the byte-in/bit-out main data FIFO wrapper and assembles N-bit fields, MSB first, for two parser clients. Client 0 is the frame header/side-info parser; client 1 is the main-data (scalefactor/Huffman) parser. Arbitration is round-robin. A read burst starts only when the wrapper's bit count covers the whole field, so a field is never split by underflow. It also keeps a running consumed-bit counter that the parsers use for byte alignment.

Parameters:
MAX_BITS, 32, widest field returned; sets the width of the data outputs and shift register
CNT_W, 16, width of the FIFO bit-count input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fifo_dcount  in  CNT_W  bits available, from the FIFO wrapper's dcount_out
fifo_dout  in  1  bit from the FIFO wrapper
fifo_d_valid  in  1  qualifies fifo_dout; wrapper asserts it 1 cycle after rd_en
fifo_rd_en  out  1  single-bit read strobe to the wrapper
req0, req1  in  1 each  level request per client
nbits0, nbits1  in  6 each  requested field width per client
data0, data1  out  MAX_BITS each  right-justified field, zero-extended
data_valid0, data_valid1  out  1 each  1-cycle completion pulse; also serves as ack
busy  out  1  high in any state other than IDLE
bits_consumed  out  32  total bits returned since reset; wraps
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; these outputs go to 0: fifo_rd_en, data0/1, data_valid0/1, busy, bits_consumed, err. Internal counters and shift register go to 0; rr_ptr=0. Reset mid-burst abandons the burst; the wrapper's count is not restored.
- Width rule: eff = (nbits==0) ? 0 : min(nbits, 32). eff is latched at grant; later changes to nbits are ignored.
- Client contract: hold req and nbits stable until data_validX; drop req the cycle after. If req drops mid-transaction, the transaction still completes and data_valid still pulses.
- Arbitration (IDLE only): one requester wins alone. If both request, the winner is rr_ptr. After serving client k, rr_ptr = ~k.
- FSM:
  - IDLE: on a winner, latch id and eff → WAIT_DATA. If eff==0 → RESP instead, with data=0.
  - WAIT_DATA: when fifo_dcount >= eff → ISSUE. Otherwise stall indefinitely; the winner is not swapped.
  - ISSUE: fifo_rd_en=1 for exactly eff consecutive cycles, tracked by an issue counter. After the last strobe → DRAIN.
  - DRAIN: leave when received + (fifo_d_valid ? 1 : 0) == eff → RESP.
  - RESP: data_valid[id]=1 and data[id]=shreg for one cycle. bits_consumed += eff. Update rr_ptr → IDLE.
- Collection: in any state, on fifo_d_valid, shreg <= {shreg[MAX_BITS-2:0], fifo_dout} and received++. shreg and received are cleared on grant.
- data0/data1 hold their last value between pulses.
- Latency: with req high in IDLE and enough data already present, data_valid rises exactly eff+3 cycles after the IDLE cycle that sampled req. Back-to-back requests add 1 cycle (RESP→IDLE).
- Simultaneous events: the wrapper may be written while a burst is issuing; the entry check alone guarantees no underflow.
- err is set and held until reset in these cases:
  - fifo_d_valid arrives in IDLE or WAIT_DATA;
  - fifo_d_valid arrives when received == eff;
  - DRAIN lasts more than 4 cycles without fifo_d_valid.
  The FSM does not change its path on err.

Test Plan:
- Load FIFO with byte 0xA5, then req0 with nbits0=4 → rd_en high 4 cycles; data_valid0 pulses at cycle 7 after req sampled, data0=0xA; bits_consumed=4.
- Then req0 with nbits0=4 → data0=0x5; bits_consumed=8; err=0.
- Empty FIFO, req1 with nbits1=12 → state held in WAIT_DATA with rd_en=0. Write bytes 0xFF, 0xF1 → data1=0xFFF; 4 bits remain (fifo_dcount=4).
- req0 and req1 asserted together, both with nbits=8, over FIFO bytes 0x12, 0x34 → client0 served first with 0x12, then client1 with 0x34; rr_ptr=0 afterwards.
- nbits0=0 → data_valid0 pulses with data0=0 and no rd_en; nbits0=40 with 5 bytes present → 32 bits returned.
- Assert rst_n low mid-ISSUE → all outputs 0 immediately. A stray fifo_d_valid injected in IDLE afterwards → err=1 and stays 1.

Source files
------------

// File: rtl/fifo_bit_reader_ctrl.sv
// rtl/fifo_bit_reader_ctrl.sv - round-robin N-bit field reader over a single-bit FIFO wrapper
//
// Reads single bits from the main data FIFO wrapper and assembles MSB-first
// fields of up to MAX_BITS bits for two parser clients (0: header/side-info,
// 1: main data). A burst is only started once the wrapper holds the whole
// field, so a field is never split by underflow.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fifo_dcount         bits available in the wrapper
//   fifo_dout           bit from the wrapper, qualified by fifo_d_valid
//   fifo_d_valid        returned-bit strobe, one cycle after fifo_rd_en
//   fifo_rd_en          single-bit read strobe
//   req0/req1           level requests per client
//   nbits0/nbits1       requested field width per client (0 allowed)
//   data0/data1         right-justified field, held between pulses
//   data_valid0/1       one-cycle completion pulse (ack)
//   busy                controller not idle
//   bits_consumed       running total of returned bits, wraps
//   err                 sticky protocol error
module fifo_bit_reader_ctrl #(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    fifo_dcount,
  input  logic                fifo_dout,
  input  logic                fifo_d_valid,
  output logic                fifo_rd_en,
  input  logic                req0,
  input  logic                req1,
  input  logic [5:0]          nbits0,
  input  logic [5:0]          nbits1,
  output logic [MAX_BITS-1:0] data0,
  output logic [MAX_BITS-1:0] data1,
  output logic                data_valid0,
  output logic                data_valid1,
  output logic                busy,
  output logic [31:0]         bits_consumed,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ISSUE     = 3'd2,
    DRAIN     = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [5:0] EFF_MAX = 6'(MAX_BITS);

  state_t              state_q, state_d;
  logic                id_q;
  logic                rr_ptr;
  logic [5:0]          eff_q;
  logic [5:0]          issue_cnt;
  logic [5:0]          received;
  logic [2:0]          drain_idle;
  logic [MAX_BITS-1:0] shreg;
  logic [MAX_BITS-1:0] data0_q, data1_q;

  logic                grant;
  logic                win;
  logic [5:0]          win_nbits;
  logic [5:0]          win_eff;

  // Arbitration: a lone requester wins; on contention rr_ptr decides.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (req0 && req1) begin
      grant = 1'b1;
      win   = rr_ptr;
    end else if (req0) begin
      grant = 1'b1;
      win   = 1'b0;
    end else if (req1) begin
      grant = 1'b1;
      win   = 1'b1;
    end
  end

  assign win_nbits = win ? nbits1 : nbits0;
  assign win_eff   = (win_nbits > EFF_MAX) ? EFF_MAX : win_nbits;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = (win_eff == 6'd0) ? RESP : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (fifo_dcount >= CNT_W'(eff_q)) state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_cnt == eff_q - 6'd1) state_d = DRAIN;
      end
      DRAIN: begin
        // The bit arriving this cycle counts toward completion.
        if (received + 6'(fifo_d_valid) == eff_q) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      id_q          <= 1'b0;
      rr_ptr        <= 1'b0;
      eff_q         <= '0;
      issue_cnt     <= '0;
      received      <= '0;
      drain_idle    <= '0;
      shreg         <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
      bits_consumed <= '0;
      err           <= 1'b0;
    end else begin
      state_q <= state_d;

      // Grant clears the collector; otherwise any returned bit is shifted in.
      if (state_q == IDLE && grant) begin
        id_q      <= win;
        eff_q     <= win_eff;
        shreg     <= '0;
        received  <= '0;
        issue_cnt <= '0;
      end else if (fifo_d_valid) begin
        shreg    <= {shreg[MAX_BITS-2:0], fifo_dout};
        received <= received + 6'd1;
      end

      if (state_q == ISSUE) issue_cnt <= issue_cnt + 6'd1;

      // Count consecutive silent DRAIN cycles; the fifth one flags a stall.
      if (state_q == DRAIN && !fifo_d_valid) begin
        if (drain_idle != 3'd7) drain_idle <= drain_idle + 3'd1;
        if (drain_idle >= 3'd4) err <= 1'b1;
      end else begin
        drain_idle <= '0;
      end

      if (fifo_d_valid &&
          (state_q == IDLE || state_q == WAIT_DATA || received == eff_q))
        err <= 1'b1;

      if (state_q == RESP) begin
        bits_consumed <= bits_consumed + 32'(eff_q);
        rr_ptr        <= ~id_q;
        if (id_q) data1_q <= shreg;
        else      data0_q <= shreg;
      end
    end
  end

  // During RESP the live field is presented; afterwards the captured copy holds it.
  assign data_valid0 = (state_q == RESP) && !id_q;
  assign data_valid1 = (state_q == RESP) &&  id_q;
  assign data0       = data_valid0 ? shreg : data0_q;
  assign data1       = data_valid1 ? shreg : data1_q;
  assign fifo_rd_en  = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_bit_reader_ctrl.sv
// tb/tb_fifo_bit_reader_ctrl.sv - self-checking bench for fifo_bit_reader_ctrl
//
// Contains a behavioural FIFO wrapper (byte writes, single-bit reads with
// one-cycle return latency) and a reference bit stream from which expected
// fields, consumed-bit totals and round-robin order are derived.
module tb_fifo_bit_reader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_dcount = '0;
  logic        fifo_dout;
  logic        fifo_d_valid;
  logic        fifo_rd_en;
  logic        req0, req1;
  logic [5:0]  nbits0, nbits1;
  logic [31:0] data0, data1;
  logic        data_valid0, data_valid1;
  logic        busy;
  logic [31:0] bits_consumed;
  logic        err;

  int errors = 0;
  int checks = 0;

  fifo_bit_reader_ctrl #(.MAX_BITS(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_dcount(fifo_dcount), .fifo_dout(fifo_dout), .fifo_d_valid(fifo_d_valid),
    .fifo_rd_en(fifo_rd_en),
    .req0(req0), .req1(req1), .nbits0(nbits0), .nbits1(nbits1),
    .data0(data0), .data1(data1), .data_valid0(data_valid0), .data_valid1(data_valid1),
    .busy(busy), .bits_consumed(bits_consumed), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO wrapper.
  bit       fifo_q[$];
  logic     wr_en = 1'b0;
  logic [7:0] wr_byte = '0;
  logic     mdl_valid = 1'b0;
  logic     mdl_bit = 1'b0;
  logic     stray = 1'b0;
  logic     stray_bit = 1'b0;

  always @(posedge clk) begin : fifo_model
    bit b;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      b = fifo_q.pop_front();
      mdl_bit   <= b;
      mdl_valid <= 1'b1;
    end else begin
      mdl_valid <= 1'b0;
    end
    if (wr_en) for (int i = 7; i >= 0; i--) fifo_q.push_back(wr_byte[i]);
    fifo_dcount <= 16'(fifo_q.size());
  end

  assign fifo_d_valid = mdl_valid | stray;
  assign fifo_dout    = mdl_valid ? mdl_bit : stray_bit;

  // Reference model state.
  bit          ref_q[$];
  int          rr_m;
  logic [31:0] cons_m;

  function automatic int eff_of(input int nb);
    return (nb == 0) ? 0 : ((nb > 32) ? 32 : nb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_byte = b;
    for (int i = 7; i >= 0; i--) ref_q.push_back(b[i]);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic take_bits(input int eff, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < eff; i++) v = (v << 1) | 32'(ref_q.pop_front());
  endtask

  task automatic wait_dv(input int c, output int cyc, output int rdc);
    cyc = 0;
    rdc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (fifo_rd_en) rdc++;
    end while (!(c == 1 ? data_valid1 : data_valid0) && cyc < 300);
  endtask

  task automatic xact(input int c, input int nb, input bit chk_lat);
    int eff, cyc, rdc;
    logic [31:0] expv;
    eff = eff_of(nb);
    take_bits(eff, expv);
    if (c == 0) begin req0 = 1'b1; nbits0 = nb[5:0]; end
    else        begin req1 = 1'b1; nbits1 = nb[5:0]; end
    wait_dv(c, cyc, rdc);
    chk("timeout", 32'(cyc < 300), 32'd1);
    chk("data", c == 1 ? data1 : data0, expv);
    chk("rd_cnt", 32'(rdc), 32'(eff));
    if (chk_lat) chk("latency", 32'(cyc), 32'((eff == 0) ? 1 : eff + 3));
    cons_m += 32'(eff);
    rr_m = 1 - c;
    @(negedge clk);
    if (c == 0) req0 = 1'b0; else req1 = 1'b0;
    chk("dv_pulse", 32'(c == 1 ? data_valid1 : data_valid0), 32'd0);
    chk("hold", c == 1 ? data1 : data0, expv);
    chk("consumed", bits_consumed, cons_m);
  endtask

  task automatic serve_both(input int nb0, input int nb1);
    int c, eff, cyc, rdc;
    logic [31:0] expv;
    req0 = 1'b1; nbits0 = nb0[5:0];
    req1 = 1'b1; nbits1 = nb1[5:0];
    c = rr_m;
    for (int k = 0; k < 2; k++) begin
      eff = eff_of(c == 1 ? nb1 : nb0);
      take_bits(eff, expv);
      wait_dv(c, cyc, rdc);
      chk("pair_timeout", 32'(cyc < 300), 32'd1);
      chk("pair_data", c == 1 ? data1 : data0, expv);
      chk("pair_rd_cnt", 32'(rdc), 32'(eff));
      cons_m += 32'(eff);
      rr_m = 1 - c;
      @(negedge clk);
      if (c == 0) req0 = 1'b0; else req1 = 1'b0;
      chk("pair_consumed", bits_consumed, cons_m);
      c = 1 - c;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb, nb2, c, n, cyc;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; nbits0 = '0; nbits1 = '0;
    rr_m = 0;
    cons_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dv", 32'({data_valid1, data_valid0}), 0);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    chk("rst_consumed", bits_consumed, 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two nibbles from 0xA5.
    load_byte(8'hA5);
    @(negedge clk);
    xact(0, 4, 1'b1);
    xact(0, 4, 1'b1);
    chk("err_after_nibbles", 32'(err), 0);

    // Stall in WAIT_DATA until 12 bits exist.
    req1 = 1'b1; nbits1 = 6'd12;
    repeat (5) begin
      @(negedge clk);
      chk("wait_rd_en", 32'(fifo_rd_en), 0);
      chk("wait_busy", 32'(busy), 1);
    end
    load_byte(8'hFF);
    load_byte(8'hF1);
    begin
      int rdc;
      logic [31:0] expv;
      take_bits(12, expv);
      wait_dv(1, cyc, rdc);
      chk("wait_timeout", 32'(cyc < 300), 1);
      chk("wait_data", data1, expv);
      chk("wait_rd_cnt", 32'(rdc), 12);
      cons_m += 32'd12;
      rr_m = 0;
      @(negedge clk);
      req1 = 1'b0;
      chk("wait_consumed", bits_consumed, cons_m);
      chk("wait_dcount", 32'(fifo_dcount), 4);
    end
    xact(1, 4, 1'b1);

    // Contention: client 0 first, then client 1.
    load_byte(8'h12);
    load_byte(8'h34);
    @(negedge clk);
    serve_both(8, 8);
    chk("rr_after_pair", 32'(rr_m), 0);

    // Zero-width and over-wide fields.
    xact(0, 0, 1'b1);
    for (int i = 0; i < 5; i++) load_byte(8'(8'h81 + 8'(i * 17)));
    @(negedge clk);
    xact(0, 40, 1'b1);

    // Randomised fields, occasional contention.
    for (int it = 0; it < 24; it++) begin
      nb = int'($urandom_range(0, 40));
      if (it % 4 == 3) begin
        nb2 = int'($urandom_range(0, 40));
        n = (eff_of(nb) + eff_of(nb2)) / 8 + 1;
        for (int i = 0; i < n; i++) load_byte(8'($urandom));
        @(negedge clk);
        serve_both(nb, nb2);
      end else begin
        c = int'($urandom_range(0, 1));
        n = eff_of(nb) / 8 + 1;
        for (int i = 0; i < n; i++) load_byte(8'($urandom));
        @(negedge clk);
        xact(c, nb, 1'b1);
      end
    end
    chk("err_after_random", 32'(err), 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) load_byte(8'($urandom));
    @(negedge clk);
    req0 = 1'b1; nbits0 = 6'd32;
    cyc = 0;
    while (!fifo_rd_en && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("issue_reached", 32'(fifo_rd_en), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data0", data0, 0);
    chk("mid_rst_data1", data1, 0);
    chk("mid_rst_dv", 32'({data_valid1, data_valid0}), 0);
    chk("mid_rst_consumed", bits_consumed, 0);
    chk("mid_rst_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Stray returned bit while idle.
    stray = 1'b1; stray_bit = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_err", 32'(err), 1);
    repeat (4) @(negedge clk);
    chk("stray_err_sticky", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
